cover_toggle_collector: RTL

Parametrised toggle-coverage collector for the formal/fuzz demo RTL. It samples a `WIDTH`-bit probe vector and records each cover point the first time it is hit in a sticky bitmap. In edge mode, rising and falling transitions are separate cover points. Each first hit is reported exactly once as an indexed event on a valid/ready stream, and the block keeps a running count of covered points.

---
 rtl/cover_toggle_collector.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: keeps a sticky bitmap of hit cover points and
// reports each first hit once, as an indexed event on a valid/ready stream.
// Pending events are served lowest point first, so the stream behaves as a
// priority queue rather than a FIFO.

// Per-probe-bit edge detector, used in edge mode. It turns one probe bit
// into a rising-edge hit and a falling-edge hit against the last enabled
// sample of that bit.
module cover_toggle_lane (
  input  logic enable,
  input  logic prev_ok,
  input  logic probe,
  input  logic prev,
  output logic rise,
  output logic fall
);
  // An edge needs a valid prior sample, otherwise power-up values would fake one
  assign rise = enable & prev_ok &  probe & ~prev;
  assign fall = enable & prev_ok & ~probe &  prev;
endmodule

module cover_toggle_collector #(
  parameter int          WIDTH       = 129,
  parameter int          EDGE_MODE   = 0,
  parameter int unsigned COVER_INDEX = 0,
  parameter int          IDX_W       = 64,
  localparam int         N           = WIDTH * (1 + EDGE_MODE),
  localparam int         CNT_W       = $clog2(N + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [WIDTH-1:0]   probe,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [IDX_W-1:0]   ev_index,
  output logic [CNT_W-1:0]   covered_count,
  output logic               all_covered
);
  // Width of a point number; a single-point block still needs one bit
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  hit;      // sticky coverage bitmap
  logic [N-1:0]  pend;     // hit but not yet reported
  logic [N-1:0]  h;        // raw hits this cycle
  logic [N-1:0]  nh;       // first-time hits this cycle
  logic [N-1:0]  sel_oh;   // lowest pending point, one-hot
  logic [N-1:0]  acc_oh;   // pending bit retired by this cycle's handshake
  logic [PW-1:0] sel;      // lowest pending point, binary
  logic [CNT_W-1:0] cnt_add;

  // Raw hit vector: level mode looks at the probe directly, edge mode needs
  // the previous sample, which only exists in that configuration.
  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [WIDTH-1:0] prev;
      logic             prev_ok;

      // Previous sample tracks the probe only while enabled, so a disabled
      // gap is bridged by comparing against the last enabled value.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          prev    <= '0;
          prev_ok <= 1'b0;
        end else begin
          if (enable) prev <= probe;
          if (clear)       prev_ok <= 1'b0;
          else if (enable) prev_ok <= 1'b1;
        end
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        cover_toggle_lane u_lane (
          .enable  (enable),
          .prev_ok (prev_ok),
          .probe   (probe[i]),
          .prev    (prev[i]),
          .rise    (h[2*i]),
          .fall    (h[2*i+1])
        );
      end
    end else begin : g_level
      assign h = {WIDTH{enable}} & probe;
    end
  endgenerate

  // Points already covered are filtered out, so each point reports once per epoch
  assign nh = h & ~hit;

  // Lowest pending point: isolate the lowest set bit and find its index
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) sel = PW'(i);
    end
  end

  assign sel_oh = pend & (~pend + N'(1));
  assign acc_oh = sel_oh & {N{ev_ready}};

  // Number of points newly covered this cycle
  always_comb begin
    cnt_add = '0;
    for (int i = 0; i < N; i++) begin
      cnt_add = cnt_add + CNT_W'(nh[i]);
    end
  end

  // Coverage state; clear beats both a simultaneous hit and a handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit           <= '0;
      pend          <= '0;
      covered_count <= '0;
    end else if (clear) begin
      hit           <= '0;
      pend          <= '0;
      covered_count <= '0;
    end else begin
      hit           <= hit | nh;
      pend          <= (pend | nh) & ~acc_oh;
      covered_count <= covered_count + cnt_add;
    end
  end

  // Event stream straight from registers; with nothing pending the index
  // rests at the base value.
  assign ev_valid    = |pend;
  assign ev_index    = IDX_W'(COVER_INDEX) + IDX_W'(sel);
  assign all_covered = (covered_count == CNT_W'(N));

endmodule
